stress_decision_unit: RTL and testbench

STRESS_DECISION_UNIT -- requirements
Module: stress_decision_unit

---
 rtl/stress_decision_unit.sv | 156 +++++++++++++++
 tb/tb_stress_decision_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stress_decision_unit.sv
// Stress decision unit: captures KNN/SVM classification results on done edges, keeps a
// history of combined results and produces a windowed majority-style stress vote with an irq.
module stress_decision_unit #(
    parameter int unsigned HIST_DEPTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [1:0]            mode,
    input  logic                  SVM_done,
    input  logic                  SVM_classification,
    input  logic                  KNN_done,
    input  logic                  KNN_classification,
    input  logic [3:0]            win_len,
    input  logic [3:0]            vote_thr,
    input  logic                  irq_ack,
    output logic                  stress_flag,
    output logic                  stress_valid,
    output logic                  irq,
    output logic [HIST_DEPTH-1:0] history,
    output logic [15:0]           decision_count
);

    localparam logic [3:0] Depth4 = 4'(HIST_DEPTH);

    typedef enum logic [1:0] {StWait, StUpdate, StDecide, StReport} state_e;

    state_e     state_q, state_d;
    logic       svm_done_q, knn_done_q, edge_mask_q;
    logic [1:0] mode_q;
    logic       pend_svm_q, pend_knn_q, cls_svm_q, cls_knn_q;
    logic [3:0] fill_q;
    logic       knn_en, svm_en, knn_rise, svm_rise, mode_chg, all_pend, combined;
    logic       do_update, do_decide, irq_clr;
    logic [3:0] win_eff, thr_eff, votes;

    assign knn_en   = mode_q[0];
    assign svm_en   = mode_q[1];
    // The first edge after reset is masked so a done already high at release is not an edge.
    assign knn_rise = KNN_done & ~knn_done_q & ~edge_mask_q & knn_en;
    assign svm_rise = SVM_done & ~svm_done_q & ~edge_mask_q & svm_en;
    assign mode_chg = (mode != mode_q);
    assign all_pend = (mode_q != 2'b00) && (!knn_en || pend_knn_q) && (!svm_en || pend_svm_q);

    always_comb begin
        case (mode_q)
            2'b01:   combined = cls_knn_q;
            2'b10:   combined = cls_svm_q;
            2'b11:   combined = cls_knn_q & cls_svm_q;
            default: combined = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StWait;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StWait:   if (all_pend) state_d = StUpdate;
            StUpdate: state_d = StDecide;
            StDecide: state_d = StReport;
            StReport: if (irq_ack) state_d = StWait;
            default:  state_d = StWait;
        endcase
        if (mode_chg) state_d = StWait;
    end

    always_comb begin
        do_update = 1'b0;
        do_decide = 1'b0;
        irq_clr   = 1'b0;
        if (!mode_chg) begin
            case (state_q)
                StUpdate: do_update = 1'b1;
                StDecide: do_decide = 1'b1;
                StReport: irq_clr   = irq_ack;
                default:  ;
            endcase
        end
    end

    always_comb begin
        win_eff = win_len;
        if (win_len == 4'd0) win_eff = 4'd1;
        else if (win_len > Depth4) win_eff = Depth4;
        thr_eff = vote_thr;
        if (vote_thr == 4'd0) thr_eff = 4'd1;
        else if (vote_thr > win_eff) thr_eff = win_eff;
        votes = 4'd0;
        for (int unsigned i = 0; i < HIST_DEPTH; i++) begin
            if (i < 32'(win_eff)) votes = votes + 4'(history[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            svm_done_q     <= 1'b0;
            knn_done_q     <= 1'b0;
            edge_mask_q    <= 1'b1;
            mode_q         <= mode;
            pend_svm_q     <= 1'b0;
            pend_knn_q     <= 1'b0;
            cls_svm_q      <= 1'b0;
            cls_knn_q      <= 1'b0;
            fill_q         <= 4'd0;
            history        <= '0;
            decision_count <= 16'd0;
            stress_flag    <= 1'b0;
            stress_valid   <= 1'b0;
            irq            <= 1'b0;
        end else begin
            svm_done_q  <= SVM_done;
            knn_done_q  <= KNN_done;
            edge_mask_q <= 1'b0;
            mode_q      <= mode;
            if (mode_chg) begin
                pend_svm_q <= 1'b0;
                pend_knn_q <= 1'b0;
                irq        <= 1'b0;
            end else begin
                if (do_update) begin
                    history        <= {history[HIST_DEPTH-2:0], combined};
                    decision_count <= decision_count + 16'd1;
                    if (fill_q < Depth4) fill_q <= fill_q + 4'd1;
                    if (knn_en) pend_knn_q <= 1'b0;
                    if (svm_en) pend_svm_q <= 1'b0;
                end
                // A new edge coinciding with the UPDATE clear wins.
                if (knn_rise) begin
                    pend_knn_q <= 1'b1;
                    cls_knn_q  <= KNN_classification;
                end
                if (svm_rise) begin
                    pend_svm_q <= 1'b1;
                    cls_svm_q  <= SVM_classification;
                end
                if (do_decide) begin
                    if (fill_q >= win_eff) begin
                        stress_valid <= 1'b1;
                        stress_flag  <= (votes >= thr_eff);
                    end else begin
                        stress_valid <= 1'b0;
                    end
                    irq <= 1'b1;
                end
                if (irq_clr) irq <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stress_decision_unit.sv
// Self-checking bench for stress_decision_unit: directed scenarios plus randomized decisions
// compared against a transaction-level model of the history/vote rules.
module tb_stress_decision_unit;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [1:0]  mode = 2'b10;
    logic        SVM_done = 1'b0, SVM_classification = 1'b0;
    logic        KNN_done = 1'b0, KNN_classification = 1'b0;
    logic [3:0]  win_len = 4'd1, vote_thr = 4'd1;
    logic        irq_ack = 1'b0;
    logic        stress_flag, stress_valid, irq;
    logic [7:0]  history;
    logic [15:0] decision_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  m_hist;
    logic [15:0] m_count;
    int          m_fill;
    bit          m_flag, m_valid;

    stress_decision_unit #(.HIST_DEPTH(8)) dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .mode               (mode),
        .SVM_done           (SVM_done),
        .SVM_classification (SVM_classification),
        .KNN_done           (KNN_done),
        .KNN_classification (KNN_classification),
        .win_len            (win_len),
        .vote_thr           (vote_thr),
        .irq_ack            (irq_ack),
        .stress_flag        (stress_flag),
        .stress_valid       (stress_valid),
        .irq                (irq),
        .history            (history),
        .decision_count     (decision_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_reset();
        m_hist  = 8'h00;
        m_count = 16'h0000;
        m_fill  = 0;
        m_flag  = 1'b0;
        m_valid = 1'b0;
    endtask

    // One accepted result: shift history, count, then vote over the newest W results.
    task automatic model_update(input bit c, input int wl, input int vt);
        int w, t, v;
        m_hist  = {m_hist[6:0], c};
        m_count = m_count + 16'd1;
        if (m_fill < 8) m_fill++;
        w = (wl == 0) ? 1 : ((wl > 8) ? 8 : wl);
        t = (vt == 0) ? 1 : ((vt > w) ? w : vt);
        if (m_fill >= w) begin
            v = 0;
            for (int i = 0; i < w; i++) v += int'(m_hist[i]);
            m_valid = 1'b1;
            m_flag  = (v >= t);
        end else begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_flag"}, stress_flag, m_flag);
        check({tag, "_valid"}, stress_valid, m_valid);
        check({tag, "_hist"}, history, m_hist);
        check({tag, "_count"}, decision_count, m_count);
    endtask

    task automatic do_reset(input logic [1:0] md);
        mode     = md;
        KNN_done = 1'b0;
        SVM_done = 1'b0;
        irq_ack  = 1'b0;
        RESET    = 1'b1;
        step();
        step();
        RESET = 1'b0;
        step();
        model_reset();
    endtask

    task automatic wait_irq(input string tag, input int exp_lat);
        int n = 0;
        while (!irq && n < 20) begin
            step();
            n++;
        end
        check(tag, n, exp_lat);
    endtask

    task automatic ack_irq();
        KNN_done = 1'b0;
        SVM_done = 1'b0;
        irq_ack  = 1'b1;
        step();
        check("irq_clear", irq, 1'b0);
        irq_ack = 1'b0;
        step();
    endtask

    task automatic run_decision(input logic [1:0] md, input bit kc, input bit sc,
                                input int wl, input int vt, input int stagger);
        bit c;
        win_len            = 4'(wl);
        vote_thr           = 4'(vt);
        KNN_classification = kc;
        SVM_classification = sc;
        if (md == 2'b11 && stagger > 0) begin
            KNN_done = 1'b1;
            repeat (stagger) step();
            check("partial_no_irq", irq, 1'b0);
            SVM_done = 1'b1;
        end else begin
            KNN_done = md[0];
            SVM_done = md[1];
        end
        wait_irq("irq_latency", 4);
        c = (md == 2'b01) ? kc : ((md == 2'b10) ? sc : (kc & sc));
        model_update(c, wl, vt);
        check_state("decision");
        ack_irq();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit [1:0] md;

        // Reset values
        do_reset(2'b10);
        check("rst_irq", irq, 1'b0);
        check_state("rst");

        // Single SVM result, W=1 thr=1
        run_decision(2'b10, 1'b0, 1'b1, 1, 1, 0);
        check("s1_hist", history, 8'h01);
        check("s1_count", decision_count, 16'd1);

        // Window of 4, threshold 3: 1,0,1,1 then 0
        do_reset(2'b10);
        run_decision(2'b10, 1'b0, 1'b1, 4, 3, 0);
        run_decision(2'b10, 1'b0, 1'b0, 4, 3, 0);
        run_decision(2'b10, 1'b0, 1'b1, 4, 3, 0);
        check("s2_valid3", stress_valid, 1'b0);
        run_decision(2'b10, 1'b0, 1'b1, 4, 3, 0);
        check("s2_flag4", stress_flag, 1'b1);
        run_decision(2'b10, 1'b0, 1'b0, 4, 3, 0);
        check("s2_hist5", history, 8'h16);
        check("s2_flag5", stress_flag, 1'b0);

        // KNN+SVM staggered by 5 cycles -> one decision, combined 0
        do_reset(2'b11);
        run_decision(2'b11, 1'b1, 1'b0, 1, 1, 5);
        repeat (8) step();
        check("s3_no_second_irq", irq, 1'b0);
        check("s3_count", decision_count, 16'd1);
        check("s3_hist", history, 8'h00);

        // SVM_done held high: one decision, then a re-rise during REPORT stays pending
        do_reset(2'b10);
        win_len = 4'd1;
        vote_thr = 4'd1;
        SVM_classification = 1'b1;
        SVM_done = 1'b1;
        wait_irq("s4_latency", 4);
        model_update(1'b1, 1, 1);
        repeat (15) step();
        check("s4_irq_held", irq, 1'b1);
        check_state("s4_held");
        SVM_done = 1'b0;
        step();
        SVM_classification = 1'b0;
        SVM_done = 1'b1;
        step();
        irq_ack = 1'b1;
        step();
        check("s4_ack_clear", irq, 1'b0);
        irq_ack = 1'b0;
        wait_irq("s4_pending_latency", 3);
        model_update(1'b0, 1, 1);
        check_state("s4_second");
        ack_irq();

        // Count wrap from 0xFFFF, then mode change while in REPORT
        force dut.decision_count = 16'hFFFF;
        step();
        release dut.decision_count;
        step();
        m_count = 16'hFFFF;
        check("s5_preload", decision_count, 16'hFFFF);
        run_decision(2'b10, 1'b0, 1'b1, 1, 1, 0);
        check("s5_wrap", decision_count, 16'h0000);
        SVM_classification = 1'b0;
        SVM_done = 1'b1;
        wait_irq("s5_latency", 4);
        model_update(1'b0, 1, 1);
        SVM_done = 1'b0;
        mode = 2'b01;
        step();
        check("s5_modechg_irq", irq, 1'b0);
        check_state("s5_modechg");
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        run_decision(2'b01, 1'b1, 1'b0, 2, 2, 0);

        // Reset in DECIDE with SVM_done held high
        do_reset(2'b10);
        SVM_classification = 1'b1;
        SVM_done = 1'b1;
        repeat (3) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        model_reset();
        check("s6_irq", irq, 1'b0);
        check_state("s6_rst");
        repeat (10) step();
        check("s6_no_irq", irq, 1'b0);
        check("s6_no_count", decision_count, 16'd0);
        SVM_done = 1'b0;
        step();
        run_decision(2'b10, 1'b0, 1'b1, 1, 1, 0);

        // Mode 00 ignores everything
        mode = 2'b00;
        step();
        KNN_done = 1'b1;
        SVM_done = 1'b1;
        repeat (8) step();
        check("m0_no_irq", irq, 1'b0);
        check("m0_count", decision_count, m_count);
        KNN_done = 1'b0;
        SVM_done = 1'b0;
        step();

        // Randomized decisions
        do_reset(2'b01);
        for (int k = 0; k < 40; k++) begin
            md = 2'($urandom_range(1, 3));
            if (md != mode) begin
                mode = md;
                step();
                step();
            end
            run_decision(md, 1'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 15)),
                         (md == 2'b11) ? int'($urandom_range(0, 4)) : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
